// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, request kinds and counter width.
package dmem_pkg;

    localparam int LAT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RELAY = 2'd2
    } state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_kind_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Per-thread data-memory valid/ready bundle between the core LSUs (master) and the responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) ();

    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    modport master (
        output consumer_read_valid,
        output consumer_read_address,
        input  consumer_read_ready,
        input  consumer_read_data,
        output consumer_write_valid,
        output consumer_write_address,
        output consumer_write_data,
        input  consumer_write_ready
    );

    modport slave (
        input  consumer_read_valid,
        input  consumer_read_address,
        output consumer_read_ready,
        output consumer_read_data,
        input  consumer_write_valid,
        input  consumer_write_address,
        input  consumer_write_data,
        output consumer_write_ready
    );

endinterface

// File: rtl/data_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins, else wraps to the lowest.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0]  upper;
    logic [N-1:0]  masked;
    logic [N-1:0]  cand;
    logic [N-1:0]  hit;
    logic [N-1:0]  pick;
    logic [IW-1:0] acc [N];

    genvar gi;

    for (gi = 0; gi < N; gi++) begin : g_mask
        assign upper[gi] = (IW'(gi) >= ptr_i);
    end

    // Requests at/above the pointer take priority; only when none exist do we wrap.
    assign masked = req_i & upper;
    assign cand   = (|masked) ? masked : req_i;

    for (gi = 0; gi < N; gi++) begin : g_pick
        if (gi == 0) begin : g_first
            assign pick[gi] = cand[gi];
            assign hit[gi]  = cand[gi];
            assign acc[gi]  = '0;
        end else begin : g_rest
            assign pick[gi] = cand[gi] & ~hit[gi-1];
            assign hit[gi]  = hit[gi-1] | cand[gi];
            assign acc[gi]  = acc[gi-1] | (pick[gi] ? IW'(gi) : '0);
        end
    end

    assign gnt_o = pick;
    assign idx_o = acc[N-1];
    assign any_o = hit[N-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: round-robin serves one read/write at a time with fixed latency, holding ready until valid drops.
// Optional DMEM_HOST_PORT_EN adds an unarbitrated host write port that wins same-address collisions.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int LATENCY       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef DMEM_HOST_PORT_EN
    input  logic                 host_write_enable,
    input  logic [ADDR_BITS-1:0] host_write_address,
    input  logic [DATA_BITS-1:0] host_write_data,
`endif
    data_mem_responder_if.slave  bus
);

    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] wr_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data;

    state_e                                  state_q;
    logic [LAT_BITS-1:0]                     cnt_q;
    logic [IW-1:0]                           rr_q;
    logic [IW-1:0]                           gnt_idx_q;
    req_kind_e                               kind_q;
    logic [ADDR_BITS-1:0]                    addr_q;
    logic [DATA_BITS-1:0]                    wdata_q;
    logic [NUM_CONSUMERS-1:0]                read_ready_q;
    logic [NUM_CONSUMERS-1:0]                write_ready_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q;
    logic [DATA_BITS-1:0]                    mem_q [2**ADDR_BITS];

    logic [NUM_CONSUMERS-1:0] arb_req;
    logic [NUM_CONSUMERS-1:0] arb_gnt;
    logic [IW-1:0]            arb_idx;
    logic                     arb_any;

    req_kind_e            kind_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic [IW-1:0]        rr_d;
    logic                 relay_valid;
    logic                 commit;
    logic                 commit_wr;

    assign rd_addr = bus.consumer_read_address;
    assign wr_addr = bus.consumer_write_address;
    assign wr_data = bus.consumer_write_data;

    assign bus.consumer_read_ready  = read_ready_q;
    assign bus.consumer_write_ready = write_ready_q;
    assign bus.consumer_read_data   = read_data_q;

    assign arb_req = bus.consumer_read_valid | bus.consumer_write_valid;

    rr_arbiter #(
        .N (NUM_CONSUMERS)
    ) u_arb (
        .req_i (arb_req),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // A read on the granted port shadows its write; the write stays pending for a later grant.
    assign kind_d = (|(arb_gnt & bus.consumer_read_valid)) ? READ : WRITE;
    assign addr_d = (kind_d == READ) ? rd_addr[arb_idx] : wr_addr[arb_idx];
    assign rr_d   = (gnt_idx_q == IW'(NUM_CONSUMERS - 1)) ? '0 : gnt_idx_q + IW'(1);

    assign relay_valid = (kind_q == READ) ? bus.consumer_read_valid[gnt_idx_q]
                                          : bus.consumer_write_valid[gnt_idx_q];

    assign commit    = (state_q == BUSY) && (cnt_q == LAT_BITS'(1));
    assign commit_wr = commit && (kind_q == WRITE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_q          <= '0;
            gnt_idx_q     <= '0;
            kind_q        <= READ;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx_q <= arb_idx;
                        kind_q    <= kind_d;
                        addr_q    <= addr_d;
                        wdata_q   <= wr_data[arb_idx];
                        cnt_q     <= LAT_BITS'(LATENCY);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        cnt_q <= '0;
                        if (kind_q == READ) begin
                            read_data_q[gnt_idx_q]  <= mem_q[addr_q];
                            read_ready_q[gnt_idx_q] <= 1'b1;
                        end else begin
                            write_ready_q[gnt_idx_q] <= 1'b1;
                        end
                        state_q <= RELAY;
                    end else begin
                        cnt_q <= cnt_q - LAT_BITS'(1);
                    end
                end
                RELAY: begin
                    if (!relay_valid) begin
                        read_ready_q  <= '0;
                        write_ready_q <= '0;
                        rr_q          <= rr_d;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Host write is issued after the consumer write so it takes precedence on a shared address.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem_q[addr_q] <= wdata_q;
        end
`ifdef DMEM_HOST_PORT_EN
        if (host_write_enable) begin
            mem_q[host_write_address] <= host_write_data;
        end
`endif
    end

endmodule
